hollywood_password_gen: RTL
===========================

# hollywood_password_gen

Brute-force candidate source that sits directly upstream of the hash core. It enumerates every password of `2*NUM_WORDS` characters over the range `CHAR_MIN..CHAR_MAX` and streams each one as a framed word sequence: one mgmt word, then `NUM_WORDS` data words. It samples the core's success pulse at the single cycle that corresponds to a complete candidate, then latches the winning password or reports exhaustion.

## Interface
- `NUM_WORDS`, default 4: data words per candidate; range 1..8.
- `CHAR_MIN`, default 8'h20: lowest character value, inclusive.
- `CHAR_MAX`, default 8'h7E: highest character value, inclusive; must be >= `CHAR_MIN`.
- `HIT_LATENCY`, default 2: cycles from the last data word to the core's result pulse.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a search from the first candidate; ignored while `busy`.
- `out_valid`  out  1  word valid toward the core.
- `out_channel`  out  1  1 = mgmt word (clears core state), 0 = data word.
- `out_data`  out  16  word payload.
- `hit`  in  1  core success pulse (core `out_valid`).
- `busy`  out  1  search in progress.
- `done`  out  1  search finished; held until the next accepted `start`.
- `found`  out  1  valid with `done`: 1 = match found, 0 = space exhausted.
- `found_pw`  out  `16*NUM_WORDS`  matching candidate; word k is at bits [16k+15:16k].
- `cand_count`  out  32  index of the last checked candidate; 0-based, saturating.

## Operation
- Candidate layout:
  - The candidate is an odometer of `2*NUM_WORDS` bytes `c[0..2N-1]`, each in `CHAR_MIN..CHAR_MAX`.
  - `c[0]` increments fastest; each byte carries into the next when it passes `CHAR_MAX`, and wraps back to `CHAR_MIN`.
  - Data word k is `{c[2k+1], c[2k]}`.
- States: IDLE, MGMT, DATA, DRAIN, DONE.
- IDLE:
  - All outputs are 0 except `found_pw` and `cand_count`, which hold their last values.
  - An accepted `start` loads every byte with `CHAR_MIN`, clears `done`, `found` and `cand_count`, and moves to MGMT.
- MGMT: emits one word with `out_valid`=1, `out_channel`=1, `out_data`=0, then moves to DATA with the word index at 0.
- DATA:
  - Emits word k with `out_channel`=0 on each cycle, for k = 0..N-1.
  - On word N-1:
    - copy the candidate into the in-flight shadow register;
    - arm the check pipeline;
    - advance the odometer.
  - If the odometer wrapped (last candidate sent), go to DRAIN; otherwise go to MGMT.
- Back-to-back framing: there are no idle cycles between candidates, so the period is N+1 cycles.
- Check pipeline:
  - A `HIT_LATENCY`-deep shift register of arm flags.
  - `hit` is sampled only when the delayed arm flag is 1.
  - `hit` in any other cycle is ignored; this covers matches on partial prefixes and the residue from a mgmt clear.
- Checked cycle:
  - `cand_count` takes the index of the candidate being checked.
  - If `hit`=1: `found_pw` ← shadow, `found`=1, `done`=1, `busy`=0, go to DONE immediately. This applies even in the middle of the next candidate; any partial words already sent are harmless.
- DRAIN: emits nothing (`out_valid`=0). It waits for the final check, then goes to DONE with `found` set to that check's result.
- DONE:
  - `out_valid`=0; `done` is held.
  - An accepted `start` behaves exactly as it does in IDLE.
- Shadow depth: a shadow depth of one is sufficient because N+1 >= `HIT_LATENCY`. This holds for every N >= 1 when `HIT_LATENCY` <= 2.
- `start` while `busy` has no effect.

## Timing
- Reset, from any state: state = IDLE, and every output and register is 0.
- First word: `start` high in cycle t gives the first mgmt word in cycle t+1 and the first data word in cycle t+2.
- Hit sampling: a last data word in cycle T is checked against `hit` in cycle T+`HIT_LATENCY`. `done`/`found` are registered and go high in cycle T+`HIT_LATENCY`+1.
- Exhaustive search length: (N+1)·M^(2N) emit cycles plus `HIT_LATENCY` drain cycles, where M = `CHAR_MAX`−`CHAR_MIN`+1.
- `cand_count` saturates at 2^32−1.

## Structure
- Shared package `hollywood_pkg`, holding:
  - the state enum `gen_state_t`;
  - the channel constants `CH_MGMT`=1 and `CH_DATA`=0;
  - the default character bounds.
- One natural sub-module, `hollywood_char_odometer`:
  - parameterised by byte count and range;
  - inputs: `load`, `inc`;
  - outputs: the byte vector and `wrap`.
- All other logic lives in the top module.

## Test plan
All scenarios use the generator connected to a real core instance.
- Framing: N=1, chars 8'h41..8'h43, core R4/R6 set to an unmatched value. Required words after `start` in cycle t:
  - t+1: mgmt word (`out_channel`=1, `out_data`=0);
  - t+2: data word 16'h4141;
  - t+3: mgmt word;
  - t+4: data word 16'h4142.
  - Over the whole run the data words appear in the order 4141, 4142, 4143, 4241, …, 4343.
- Match: same setup, core R4=16'h4243, R6=16'h4342 (the hash of data word 16'h4342). Required: `done`=1, `found`=1, `found_pw`=16'h4342, `cand_count`=7.
- Exhaustion: same setup, unmatched R4/R6. Required:
  - after 9 candidates, `done`=1, `found`=0, `cand_count`=8;
  - no words emitted after the last data word.
- Prefix false hit: N=2, chars 8'h41..8'h42, core R4/R6 set to the state after the single word 16'h4141. Required: `hit` pulses mid-candidate but `found` stays 0, and the run ends exhausted with `cand_count`=15.
- Reset mid-run: assert `reset` during DATA. Required: all outputs 0 in the same cycle. A fresh `start` then restarts at candidate 0, and the match scenario still produces `cand_count`=7.
- Start while busy: pulse `start` mid-search. Required: no restart; the candidate sequence and final result are identical to a run without the extra pulse.

Source files
------------

// File: rtl/hollywood_pkg.sv
// Shared types and constants for the brute-force password generator.
// Holds the FSM state encoding, the word channel codes and the default character range.
package hollywood_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MGMT  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } gen_state_t;

  localparam logic CH_MGMT = 1'b1;
  localparam logic CH_DATA = 1'b0;

  localparam logic [7:0] DEF_CHAR_MIN = 8'h20;
  localparam logic [7:0] DEF_CHAR_MAX = 8'h7E;

endpackage

// File: rtl/hollywood_char_odometer.sv
// Byte odometer over CHAR_MIN..CHAR_MAX; byte 0 turns fastest.
// wrap is the carry out of the top byte, so it is only meaningful while inc is high.
module hollywood_char_odometer
  import hollywood_pkg::*;
#(
  parameter int         NUM_BYTES = 8,
  parameter logic [7:0] CHAR_MIN  = DEF_CHAR_MIN,
  parameter logic [7:0] CHAR_MAX  = DEF_CHAR_MAX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   inc,
  output logic [8*NUM_BYTES-1:0] chars,
  output logic                   wrap
);

  logic [NUM_BYTES:0]   carry;
  logic [NUM_BYTES-1:0] at_max;

  assign carry[0] = inc;
  assign wrap     = carry[NUM_BYTES];

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
    logic [7:0] byte_q, byte_d;

    assign at_max[gi]      = (byte_q == CHAR_MAX);
    assign carry[gi+1]     = carry[gi] & at_max[gi];
    assign chars[8*gi +: 8] = byte_q;

    always_comb begin
      byte_d = byte_q;
      if (load) begin
        byte_d = CHAR_MIN;
      end else if (carry[gi]) begin
        byte_d = at_max[gi] ? CHAR_MIN : byte_q + 8'd1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) byte_q <= 8'd0;
      else       byte_q <= byte_d;
    end
  end

endmodule

// File: rtl/hollywood_password_gen.sv
// Streams every candidate password to the hash core as mgmt + NUM_WORDS data words,
// checks the core's hit pulse at the cycle matching each full candidate, and latches the result.
module hollywood_password_gen
  import hollywood_pkg::*;
#(
  parameter int         NUM_WORDS   = 4,
  parameter logic [7:0] CHAR_MIN    = DEF_CHAR_MIN,
  parameter logic [7:0] CHAR_MAX    = DEF_CHAR_MAX,
  parameter int         HIT_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   out_valid,
  output logic                   out_channel,
  output logic [15:0]            out_data,
  input  logic                   hit,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [16*NUM_WORDS-1:0] found_pw,
  output logic [31:0]            cand_count
);

  localparam int PW_W  = 16 * NUM_WORDS;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  gen_state_t             state_q, state_d;
  logic [IDX_W-1:0]       widx_q, widx_d;
  logic [PW_W-1:0]        shadow_q, shadow_d;
  logic [31:0]            shadow_idx_q, shadow_idx_d;
  logic [31:0]            issue_idx_q, issue_idx_d;
  logic [31:0]            cand_count_q, cand_count_d;
  logic [PW_W-1:0]        found_pw_q, found_pw_d;
  logic                   done_q, done_d;
  logic                   found_q, found_d;
  logic [HIT_LATENCY-1:0] arm_q, arm_d;

  logic            odo_load, odo_inc, odo_wrap, arm_in, check;
  logic [PW_W-1:0] cand;

  hollywood_char_odometer #(
    .NUM_BYTES(2 * NUM_WORDS),
    .CHAR_MIN (CHAR_MIN),
    .CHAR_MAX (CHAR_MAX)
  ) u_odometer (
    .clk  (clk),
    .reset(reset),
    .load (odo_load),
    .inc  (odo_inc),
    .chars(cand),
    .wrap (odo_wrap)
  );

  assign busy       = (state_q == ST_MGMT) || (state_q == ST_DATA) || (state_q == ST_DRAIN);
  assign check      = busy && arm_q[HIT_LATENCY-1];
  assign done       = done_q;
  assign found      = found_q;
  assign found_pw   = found_pw_q;
  assign cand_count = cand_count_q;

  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    shadow_d     = shadow_q;
    shadow_idx_d = shadow_idx_q;
    issue_idx_d  = issue_idx_q;
    cand_count_d = cand_count_q;
    found_pw_d   = found_pw_q;
    done_d       = done_q;
    found_d      = found_q;
    odo_load     = 1'b0;
    odo_inc      = 1'b0;
    arm_in       = 1'b0;
    out_valid    = 1'b0;
    out_channel  = CH_DATA;
    out_data     = 16'h0000;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_MGMT;
          odo_load     = 1'b1;
          done_d       = 1'b0;
          found_d      = 1'b0;
          cand_count_d = 32'd0;
          issue_idx_d  = 32'd0;
        end
      end
      ST_MGMT: begin
        out_valid   = 1'b1;
        out_channel = CH_MGMT;
        widx_d      = '0;
        state_d     = ST_DATA;
      end
      ST_DATA: begin
        out_valid = 1'b1;
        out_data  = cand[{widx_q, 4'b0000} +: 16];
        if (widx_q == LAST_IDX) begin
          // Candidate fully sent: freeze it for the pending check, then step the odometer.
          shadow_d     = cand;
          shadow_idx_d = issue_idx_q;
          issue_idx_d  = (issue_idx_q == 32'hFFFF_FFFF) ? issue_idx_q : issue_idx_q + 32'd1;
          arm_in       = 1'b1;
          odo_inc      = 1'b1;
          state_d      = odo_wrap ? ST_DRAIN : ST_MGMT;
        end else begin
          widx_d = widx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
      end
      default: state_d = ST_IDLE;
    endcase

    // The checked cycle overrides whatever framing step was about to happen.
    if (check) begin
      cand_count_d = shadow_idx_q;
      if (hit) begin
        found_pw_d = shadow_q;
        found_d    = 1'b1;
        done_d     = 1'b1;
        state_d    = ST_DONE;
      end else if (state_q == ST_DRAIN) begin
        found_d = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
    end

    arm_d = odo_load ? '0 : HIT_LATENCY'({arm_q, arm_in});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      widx_q       <= '0;
      shadow_q     <= '0;
      shadow_idx_q <= 32'd0;
      issue_idx_q  <= 32'd0;
      cand_count_q <= 32'd0;
      found_pw_q   <= '0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      arm_q        <= '0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      shadow_q     <= shadow_d;
      shadow_idx_q <= shadow_idx_d;
      issue_idx_q  <= issue_idx_d;
      cand_count_q <= cand_count_d;
      found_pw_q   <= found_pw_d;
      done_q       <= done_d;
      found_q      <= found_d;
      arm_q        <= arm_d;
    end
  end

endmodule
